// File: rtl/stack_executor_pkg.sv
// Shared opcodes, FSM state type and per-opcode occupancy rules for stack_executor.
package stack_executor_pkg;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_PUSHI = 4'd1;
   localparam logic [3:0] OP_DROP  = 4'd2;
   localparam logic [3:0] OP_DUP   = 4'd3;
   localparam logic [3:0] OP_OVER  = 4'd4;
   localparam logic [3:0] OP_SWAP  = 4'd5;
   localparam logic [3:0] OP_ADD   = 4'd6;
   localparam logic [3:0] OP_SUB   = 4'd7;
   localparam logic [3:0] OP_AND   = 4'd8;
   localparam logic [3:0] OP_OR    = 4'd9;
   localparam logic [3:0] OP_XOR   = 4'd10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      POP   = 2'd1,
      PUSH  = 2'd2,
      PUSH2 = 2'd3
   } state_t;

   // need: minimum occupancy; room: command grows the stack and needs a free slot
   typedef struct packed {
      logic       legal;
      logic [1:0] need;
      logic       room;
   } occ_t;

   function automatic occ_t op_occupancy(input logic [3:0] op);
      occ_t occ;
      occ.legal = 1'b1;
      occ.need  = 2'd0;
      occ.room  = 1'b0;
      case (op)
         OP_NOP:   occ.need = 2'd0;
         OP_PUSHI: occ.room = 1'b1;
         OP_DROP:  occ.need = 2'd1;
         OP_DUP: begin
            occ.need = 2'd1;
            occ.room = 1'b1;
         end
         OP_OVER: begin
            occ.need = 2'd2;
            occ.room = 1'b1;
         end
         OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: occ.need = 2'd2;
         default:  occ.legal = 1'b0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/stack_executor_alu.sv
// Combinational result generator for stack_executor.
// STACK_EXECUTOR_CARRY_EN: when defined, ADD/SUB put carry/borrow in the flag bit.
module stack_executor_alu
   import stack_executor_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [3:0]     op,
   input  logic [WIDTH:0] p0,
   input  logic [WIDTH:0] p1,
   output logic [WIDTH:0] result
);

`ifdef STACK_EXECUTOR_CARRY_EN
   localparam logic CARRY_EN = 1'b1;
`else
   localparam logic CARRY_EN = 1'b0;
`endif

   logic [WIDTH:0] sum_s;
   logic [WIDTH:0] diff_s;

   // Arithmetic on the data field; the extra top bit of sum/diff is carry/borrow
   always_comb begin
      sum_s  = {1'b0, p1[WIDTH-1:0]} + {1'b0, p0[WIDTH-1:0]};
      diff_s = {1'b0, p1[WIDTH-1:0]} - {1'b0, p0[WIDTH-1:0]};
      case (op)
         OP_DUP, OP_SWAP: result = p0;
         OP_OVER:         result = p1;
         OP_ADD:          result = {sum_s[WIDTH] & CARRY_EN, sum_s[WIDTH-1:0]};
         OP_SUB:          result = {diff_s[WIDTH] & CARRY_EN, diff_s[WIDTH-1:0]};
         OP_AND:          result = p1 & p0;
         OP_OR:           result = p1 | p0;
         OP_XOR:          result = p1 ^ p0;
         default:         result = '0;
      endcase
   end

endmodule

// File: rtl/stack_executor.sv
// Command sequencer driving an operand stack's push/pop port with occupancy checking.
// Optional carry/borrow flag on ADD/SUB via STACK_EXECUTOR_CARRY_EN (see stack_executor_alu).
module stack_executor
   import stack_executor_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 127
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [3:0]                   cmd_op,
   input  logic [WIDTH:0]               cmd_imm,
   input  logic [WIDTH:0]               preview0,
   input  logic [WIDTH:0]               preview1,
   output logic                         push,
   output logic [2:0]                   pop,
   output logic [WIDTH:0]               push_data,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         err
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

   state_t         state_r, state_s;
   logic [3:0]     op_r, op_s;
   logic [WIDTH:0] res_r, res_s;
   logic [WIDTH:0] res2_r, res2_s;
   logic           push_r, push_s;
   logic [2:0]     pop_r, pop_s;
   logic [WIDTH:0] push_data_r, push_data_s;
   logic [DW-1:0]  depth_r, depth_s;
   logic           err_r, err_s;
   logic           cmd_ready_r;
   logic [WIDTH:0] alu_res_s;
   occ_t           occ_s;
   logic           reject_s;

   stack_executor_alu #(.WIDTH(WIDTH)) u_alu (
      .op     (cmd_op),
      .p0     (preview0),
      .p1     (preview1),
      .result (alu_res_s)
   );

   // Occupancy check of the offered command against the current depth
   always_comb begin
      occ_s    = op_occupancy(cmd_op);
      reject_s = !occ_s.legal
                 || (depth_r < DW'(occ_s.need))
                 || (occ_s.room && (depth_r == DEPTH_MAX));
   end

   // Next-state and next-output logic; outputs describe the cycle being entered
   always_comb begin
      state_s     = state_r;
      op_s        = op_r;
      res_s       = res_r;
      res2_s      = res2_r;
      push_s      = 1'b0;
      pop_s       = 3'd0;
      push_data_s = push_data_r;
      depth_s     = depth_r;
      err_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (cmd_valid) begin
               if (reject_s) begin
                  err_s = 1'b1;
               end else begin
                  op_s   = cmd_op;
                  res_s  = alu_res_s;
                  res2_s = preview1;
                  case (cmd_op)
                     OP_NOP: state_s = IDLE;
                     OP_PUSHI: begin
                        state_s     = PUSH;
                        push_s      = 1'b1;
                        push_data_s = cmd_imm;
                        depth_s     = depth_r + DW'(1);
                     end
                     OP_DUP, OP_OVER: begin
                        state_s     = PUSH;
                        push_s      = 1'b1;
                        push_data_s = alu_res_s;
                        depth_s     = depth_r + DW'(1);
                     end
                     OP_DROP: begin
                        state_s = POP;
                        pop_s   = 3'd1;
                        depth_s = depth_r - DW'(1);
                     end
                     default: begin
                        state_s = POP;
                        pop_s   = 3'd2;
                        depth_s = depth_r - DW'(2);
                     end
                  endcase
               end
            end else begin
               state_s = IDLE;
            end
         end
         POP: begin
            if (op_r == OP_DROP) begin
               state_s = IDLE;
            end else begin
               state_s     = PUSH;
               push_s      = 1'b1;
               push_data_s = res_r;
               depth_s     = depth_r + DW'(1);
            end
         end
         PUSH: begin
            if (op_r == OP_SWAP) begin
               state_s     = PUSH2;
               push_s      = 1'b1;
               push_data_s = res2_r;
               depth_s     = depth_r + DW'(1);
            end else begin
               state_s = IDLE;
            end
         end
         PUSH2:   state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         op_r        <= OP_NOP;
         res_r       <= '0;
         res2_r      <= '0;
         push_r      <= 1'b0;
         pop_r       <= 3'd0;
         push_data_r <= '0;
         depth_r     <= '0;
         err_r       <= 1'b0;
         cmd_ready_r <= 1'b1;
      end else begin
         state_r     <= state_s;
         op_r        <= op_s;
         res_r       <= res_s;
         res2_r      <= res2_s;
         push_r      <= push_s;
         pop_r       <= pop_s;
         push_data_r <= push_data_s;
         depth_r     <= depth_s;
         err_r       <= err_s;
         cmd_ready_r <= (state_s == IDLE);
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign push      = push_r;
   assign pop       = pop_r;
   assign push_data = push_data_r;
   assign depth     = depth_r;
   assign err       = err_r;

endmodule

// File: tb/tb_stack_executor.sv
// Randomized self-checking bench for stack_executor with a queue-based stack reference.
module tb_stack_executor;

   localparam int WIDTH = 16;
   localparam int DEPTH = 127;
   localparam int DW    = $clog2(DEPTH + 1);

`ifdef STACK_EXECUTOR_CARRY_EN
   localparam bit CARRY = 1'b1;
`else
   localparam bit CARRY = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   logic [3:0]     cmd_op = 4'd0;
   logic [WIDTH:0] cmd_imm = '0;
   logic [WIDTH:0] preview0, preview1;
   logic           push;
   logic [2:0]     pop;
   logic [WIDTH:0] push_data;
   logic [DW-1:0]  depth;
   logic           err;

   int checks = 0;
   int errors = 0;

   logic [WIDTH:0] ref_q[$];

   // The attached Stack: storage driven by the DUT strobes
   logic [WIDTH:0] mem [0:DEPTH-1];
   int             sp = 0;

   stack_executor #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_imm   (cmd_imm),
      .preview0  (preview0),
      .preview1  (preview1),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .depth     (depth),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) begin
         sp <= 0;
      end else if (push) begin
         if (sp < DEPTH) begin
            mem[sp] <= push_data;
            sp      <= sp + 1;
         end
      end else if (pop != 3'd0) begin
         if (sp >= int'(pop)) sp <= sp - int'(pop);
      end
   end

   always_comb begin
      preview0 = '0;
      preview1 = '0;
      if (sp >= 1) preview0 = mem[sp-1];
      if (sp >= 2) preview1 = mem[sp-2];
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH:0] ref_result(input logic [3:0] op,
                                                  input logic [WIDTH:0] p0,
                                                  input logic [WIDTH:0] p1);
      int unsigned a, b, r;
      logic hi;
      logic [WIDTH:0] res;
      a = int'(p1[WIDTH-1:0]);
      b = int'(p0[WIDTH-1:0]);
      res = '0;
      case (op)
         4'd6: begin
            r = (a + b) % 65536;
            hi = (a + b) >= 65536;
            res = {hi & CARRY, r[15:0]};
         end
         4'd7: begin
            r = (a + 65536 - b) % 65536;
            hi = a < b;
            res = {hi & CARRY, r[15:0]};
         end
         4'd8: res = p1 & p0;
         4'd9: res = p1 | p0;
         4'd10: res = p1 ^ p0;
         default: res = '0;
      endcase
      return res;
   endfunction

   // Issue one command at a negedge where ready is expected; checks every following cycle
   task automatic run_cmd(input logic [3:0] op, input logic [WIDTH:0] imm);
      int d, need, n;
      bit room, reject;
      logic [WIDTH:0] p0, p1, r;
      logic e_push[4];
      logic [2:0] e_pop[4];
      logic [WIDTH:0] e_data[4];
      int e_depth[4];
      d  = ref_q.size();
      p0 = (d >= 1) ? ref_q[d-1] : '0;
      p1 = (d >= 2) ? ref_q[d-2] : '0;
      room = (op == 4'd1) || (op == 4'd3) || (op == 4'd4);
      need = (op == 4'd2 || op == 4'd3) ? 1 : ((op >= 4'd4 && op <= 4'd10) ? 2 : 0);
      reject = (op > 4'd10) || (d < need) || (room && d == DEPTH);
      n = 0;
      if (!reject) begin
         case (op)
            4'd1, 4'd3, 4'd4: begin
               e_push[0] = 1'b1; e_pop[0] = 3'd0; e_depth[0] = d + 1;
               e_data[0] = (op == 4'd1) ? imm : ((op == 4'd3) ? p0 : p1);
               ref_q.push_back(e_data[0]);
               n = 1;
            end
            4'd2: begin
               e_push[0] = 1'b0; e_pop[0] = 3'd1; e_depth[0] = d - 1; e_data[0] = '0;
               void'(ref_q.pop_back());
               n = 1;
            end
            4'd5: begin
               e_push[0] = 1'b0; e_pop[0] = 3'd2; e_depth[0] = d - 2; e_data[0] = '0;
               e_push[1] = 1'b1; e_pop[1] = 3'd0; e_depth[1] = d - 1; e_data[1] = p0;
               e_push[2] = 1'b1; e_pop[2] = 3'd0; e_depth[2] = d;     e_data[2] = p1;
               void'(ref_q.pop_back()); void'(ref_q.pop_back());
               ref_q.push_back(p0); ref_q.push_back(p1);
               n = 3;
            end
            4'd0: n = 0;
            default: begin
               r = ref_result(op, p0, p1);
               e_push[0] = 1'b0; e_pop[0] = 3'd2; e_depth[0] = d - 2; e_data[0] = '0;
               e_push[1] = 1'b1; e_pop[1] = 3'd0; e_depth[1] = d - 1; e_data[1] = r;
               void'(ref_q.pop_back()); void'(ref_q.pop_back());
               ref_q.push_back(r);
               n = 2;
            end
         endcase
      end
      for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
      check_value("ready_before", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_imm   = imm;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 4'($urandom);
      cmd_imm   = 17'($urandom);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check_value("step_push", {31'd0, push}, {31'd0, e_push[k]});
         check_value("step_pop", {29'd0, pop}, {29'd0, e_pop[k]});
         if (e_push[k]) check_value("step_data", {15'd0, push_data}, {15'd0, e_data[k]});
         check_value("step_depth", {25'd0, depth}, e_depth[k]);
         check_value("step_ready", {31'd0, cmd_ready}, 32'd0);
         check_value("step_err", {31'd0, err}, 32'd0);
      end
      @(negedge clk);
      check_value("end_err", {31'd0, err}, {31'd0, reject});
      check_value("end_ready", {31'd0, cmd_ready}, 32'd1);
      check_value("end_push", {31'd0, push}, 32'd0);
      check_value("end_pop", {29'd0, pop}, 32'd0);
      check_value("end_depth", {25'd0, depth}, ref_q.size());
      check_value("stack_size", sp, ref_q.size());
      if (ref_q.size() >= 1)
         check_value("stack_top", {15'd0, preview0}, {15'd0, ref_q[ref_q.size()-1]});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_value("rst_ready", {31'd0, cmd_ready}, 32'd1);
      check_value("rst_push", {31'd0, push}, 32'd0);
      check_value("rst_pop", {29'd0, pop}, 32'd0);
      check_value("rst_data", {15'd0, push_data}, 32'd0);
      check_value("rst_depth", {25'd0, depth}, 32'd0);
      check_value("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b0;
      ref_q.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] op;
      do_reset();

      run_cmd(4'd1, 17'd5);
      run_cmd(4'd1, 17'd7);
      run_cmd(4'd6, 17'd0);
      check_value("add_top", {15'd0, preview0}, 32'd12);

      do_reset();
      run_cmd(4'd1, 17'd3);
      run_cmd(4'd1, 17'd9);
      run_cmd(4'd7, 17'd0);
      check_value("sub_top", {15'd0, preview0}, CARRY ? 32'h1FFFA : 32'h0FFFA);

      do_reset();
      run_cmd(4'd1, 17'd1);
      run_cmd(4'd1, 17'd2);
      run_cmd(4'd5, 17'd0);
      check_value("swap_p0", {15'd0, preview0}, 32'd1);
      check_value("swap_p1", {15'd0, preview1}, 32'd2);

      do_reset();
      run_cmd(4'd2, 17'd0);
      run_cmd(4'd1, 17'h1ABCD);
      run_cmd(4'd6, 17'd0);
      run_cmd(4'd13, 17'd0);
      run_cmd(4'd0, 17'd0);

      do_reset();
      for (int i = 0; i < DEPTH; i++) run_cmd(4'd1, 17'($urandom));
      check_value("full_depth", {25'd0, depth}, DEPTH);
      run_cmd(4'd3, 17'd0);
      run_cmd(4'd1, 17'd1);
      run_cmd(4'd4, 17'd0);
      run_cmd(4'd8, 17'd0);

      // Reset in the cycle after a binary-op handshake
      do_reset();
      run_cmd(4'd1, 17'd4);
      run_cmd(4'd1, 17'd6);
      cmd_valid = 1'b1;
      cmd_op    = 4'd6;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check_value("mid_pop", {29'd0, pop}, 32'd2);
      rst = 1'b1;
      @(negedge clk);
      check_value("mid_push", {31'd0, push}, 32'd0);
      check_value("mid_ready", {31'd0, cmd_ready}, 32'd1);
      check_value("mid_depth", {25'd0, depth}, 32'd0);
      rst = 1'b0;
      ref_q.delete();

      for (int i = 0; i < 400; i++) begin
         op = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) op = 4'd1;
         run_cmd(op, 17'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack_executor.md
# stack_executor

Command sequencer that drives the operand Stack's push/pop port. It accepts one stack-machine command at a time over a valid/ready handshake and samples the Stack's preview0/preview1 outputs. It then issues the pop and push cycles needed to execute the command. It also tracks stack occupancy so it can reject underflowing or overflowing commands before touching the Stack.

## Interface
- WIDTH, 16, data width; stack words are WIDTH+1 bits, and bit WIDTH is the flag bit.
- DEPTH, 127, Stack capacity in words; must match the attached Stack instance.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  executor idle and able to accept a command.
- cmd_op  in  4  opcode, as listed under Operation.
- cmd_imm  in  WIDTH+1  immediate value for PUSHI.
- preview0  in  WIDTH+1  top of stack, from the Stack.
- preview1  in  WIDTH+1  second entry, from the Stack.
- push  out  1  Stack push strobe.
- pop  out  3  Stack pop count; only 0, 1 or 2 are ever driven.
- push_data  out  WIDTH+1  word pushed when push=1.
- depth  out  $clog2(DEPTH+1)  current occupancy.
- err  out  1  one-cycle pulse on a rejected command.

## Operation
- Opcodes:
  - 0 NOP: no stack effect.
  - 1 PUSHI: push cmd_imm.
  - 2 DROP: pop 1.
  - 3 DUP: push p0.
  - 4 OVER: push p1.
  - 5 SWAP: pop 2, push p0, then push p1.
  - 6 ADD: pop 2, push p1+p0.
  - 7 SUB: pop 2, push p1−p0.
  - 8 AND, 9 OR, 10 XOR: pop 2, push p1 op p0.
  - 11–15: illegal.
- p0 and p1 are preview0 and preview1, sampled in the handshake cycle. All results are computed in that cycle and registered.
- Arithmetic is on bits [WIDTH-1:0] only and wraps modulo 2^WIDTH.
- Logic ops act on all WIDTH+1 bits.
- States:
  - IDLE: cmd_ready=1. A handshake moves to POP (DROP and binary ops), PUSH (PUSHI/DUP/OVER) or stays in IDLE (NOP, rejected command).
  - POP: drive pop for one cycle, then go to PUSH, or to IDLE for DROP.
  - PUSH: drive push for one cycle, then go to PUSH2 for SWAP, else IDLE.
  - PUSH2: drive the second SWAP push, then go to IDLE.
- push and a nonzero pop are never asserted in the same cycle.
- Required occupancy:
  - DROP needs depth≥1; DUP needs ≥1; OVER needs ≥2; binary ops and SWAP need ≥2.
  - PUSHI/DUP/OVER need depth<DEPTH.
- Rejection: a command failing its occupancy check, or an illegal opcode, is accepted (handshake completes) and pulses err in the next cycle. It causes no push or pop, and depth is unchanged.
- depth updates in the same cycle the push or pop strobe is driven; it reflects the Stack's state after that clock edge.

## Timing
- Handshake at cycle T means cmd_valid & cmd_ready.
- Outputs are registered and appear in T+1.
- PUSHI/DUP/OVER: push in T+1; cmd_ready is back high in T+2, with new previews valid.
- DROP: pop=1 in T+1; ready in T+2.
- Binary ops: pop=2 in T+1 and push in T+2; ready in T+3.
- SWAP: pop=2 in T+1, push p0 in T+2, push p1 in T+3; ready in T+4.
- NOP/rejected command: ready stays high; the next command can be accepted in T+1.
- cmd_op and cmd_imm are only sampled at the handshake and may change afterwards.
- Reset values: cmd_ready=1, push=0, pop=0, push_data=0, depth=0, err=0, state IDLE.
- Reset mid-operation abandons the sequence immediately; no further strobes are issued. The Stack has no reset, so the system must only assert rst when the Stack's logical contents may be discarded.

## Configuration
- Macro STACK_EXECUTOR_CARRY_EN.
- Defined: ADD writes the carry-out into bit WIDTH of the result, and SUB writes borrow (1 when p1<p0 unsigned).
- Undefined: bit WIDTH of ADD/SUB results is 0.
- Logic ops and other commands are identical either way.

## Structure
- Package stack_executor_pkg holds:
  - opcode localparams OP_NOP…OP_XOR;
  - the state enum typedef (IDLE, POP, PUSH, PUSH2);
  - a function returning required/added occupancy per opcode.
- Sub-module stack_executor_alu: purely combinational (op, p0, p1) → result, containing the carry option.
- The FSM, occupancy check and output registers stay in the top.

## Test plan
- PUSHI 5, PUSHI 7, ADD:
  - push_data=5 then 7, then pop=2 followed by push_data=12; depth reads 1, 2, 0, 1.
  - The Stack's preview0=12.
- PUSHI 3, PUSHI 9, SUB with carry enabled: result 0x1FFFA, i.e. bit16=1 (borrow) and the low 16 bits are 0xFFFA (3−9 mod 2^16). Without the macro the result is 0x0FFFA.
- PUSHI 1, PUSHI 2, SWAP:
  - pop=2, then push 2, then push 1; ready is low for 3 cycles.
  - Afterwards preview0=1, preview1=2.
- Empty stack:
  - DROP → err pulse, no pop, depth=0.
  - ADD with depth=1 → err pulse, depth stays 1.
  - Opcode 13 → err pulse.
- Fill to depth=127 with PUSHI, then DUP → err pulse, no push; depth stays 127.
- Assert rst in the cycle after a binary-op handshake → no push follows, cmd_ready=1, depth=0 in the next cycle.
